// File: rtl/conversor_bcd_bin.sv
// conversor_bcd_bin
// Sequential BCD-to-binary converter for the CPU input path. A 5-digit BCD
// magnitude plus a sign flag is turned into a 16-bit two's-complement word.
// The magnitude is recovered with reverse double-dabble: shift {bcd, bin17}
// right by one and subtract 3 from every BCD digit that lands at >= 8.
// After 17 shifts the BCD field is empty and bin17 holds the magnitude.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, sampled only in IDLE
//   sinal  in   sign of entered number (1 = negative)
//   bcd    in   [19:16] ten-thousands ... [3:0] units
//   bin    out  registered two's-complement result, held until next done
//   erro   out  registered: invalid digit or out-of-range value
//   done   out  registered one-cycle result-valid pulse
//   busy   out  high whenever the state is not IDLE
module conversor_bcd_bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sinal,
    input  logic [19:0] bcd,
    output logic [15:0] bin,
    output logic        erro,
    output logic        done,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_SIGN  = 2'd3;

    // Iteration index of the last shift (17 shifts: 0..16)
    localparam logic [4:0] LAST_ITER = 5'd16;

    logic [1:0]  r_state;
    logic [19:0] r_bcd;
    logic [16:0] r_bin17;
    logic        r_sign;
    logic [4:0]  r_cnt;
    logic [15:0] r_bin;
    logic        r_erro;
    logic        r_done;

    logic [36:0] w_shift;
    logic [19:0] w_bcd_corr;
    logic [4:0]  w_dig_bad;
    logic [15:0] w_neg;

    assign w_shift = {r_bcd, r_bin17} >> 1;

    // Per-digit correction and validity check, all five digits in parallel
    for (genvar g = 0; g < 5; g++) begin : g_digit
        assign w_bcd_corr[4*g +: 4] = (w_shift[17 + 4*g +: 4] >= 4'd8)
                                    ? w_shift[17 + 4*g +: 4] - 4'd3
                                    : w_shift[17 + 4*g +: 4];
        assign w_dig_bad[g] = (r_bcd[4*g +: 4] > 4'd9);
    end

    // Only the low 16 bits of the negated magnitude survive; magnitudes
    // up to 32768 negate correctly in 16 bits (32768 -> 0x8000, 0 -> 0x0000).
    assign w_neg = ~r_bin17[15:0] + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bcd   <= 20'd0;
            r_bin17 <= 17'd0;
            r_sign  <= 1'b0;
            r_cnt   <= 5'd0;
            r_bin   <= 16'd0;
            r_erro  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bcd   <= bcd;
                        r_sign  <= sinal;
                        r_bin17 <= 17'd0;
                        r_cnt   <= 5'd0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (|w_dig_bad) begin
                        r_bin   <= 16'h0000;
                        r_erro  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_corr;
                    r_bin17 <= w_shift[16:0];
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == LAST_ITER)
                        r_state <= S_SIGN;
                end
                S_SIGN: begin
                    if (!r_sign) begin
                        if (r_bin17 > 17'd32767) begin
                            r_bin  <= 16'h7FFF;
                            r_erro <= 1'b1;
                        end else begin
                            r_bin  <= r_bin17[15:0];
                            r_erro <= 1'b0;
                        end
                    end else begin
                        if (r_bin17 > 17'd32768) begin
                            r_bin  <= 16'h8000;
                            r_erro <= 1'b1;
                        end else begin
                            r_bin  <= w_neg;
                            r_erro <= 1'b0;
                        end
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bin  = r_bin;
    assign erro = r_erro;
    assign done = r_done;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_conversor_bcd_bin.sv
// Scoreboard bench for conversor_bcd_bin: stimulus pushes the expected
// {bin, erro, done-cycle} computed arithmetically from the BCD digits; a
// monitor pops and compares on every done pulse.
module tb_conversor_bcd_bin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sinal;
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        erro;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] bin;
        logic        erro;
        int          cyc;
    } exp_t;

    exp_t q[$];

    conversor_bcd_bin dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sinal (sinal),
        .bcd   (bcd),
        .bin   (bin),
        .erro  (erro),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: decimal value from digits, then range/sign rules
    function automatic exp_t model(input logic [19:0] b, input logic s);
        exp_t e;
        int   mag = 0;
        int   pw  = 1;
        bit   bad = 0;
        for (int k = 0; k < 5; k++) begin
            int d;
            d = int'(b[4*k +: 4]);
            if (d > 9) bad = 1;
            mag += d * pw;
            pw  *= 10;
        end
        if (bad) begin
            e.bin = 16'h0000; e.erro = 1'b1; e.cyc = 1;
        end else begin
            e.cyc = 19;
            if (!s) begin
                if (mag > 32767) begin e.bin = 16'h7FFF; e.erro = 1'b1; end
                else             begin e.bin = 16'(mag); e.erro = 1'b0; end
            end else begin
                if (mag > 32768) begin e.bin = 16'h8000; e.erro = 1'b1; end
                else             begin e.bin = 16'(65536 - mag); e.erro = 1'b0; end
            end
        end
        return e;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] b;
        int          t;
        b = 20'd0;
        t = v;
        for (int k = 0; k < 5; k++) begin
            b[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Waits for IDLE, then presents one start pulse; returns just after E0
    task automatic issue(input logic [19:0] b, input logic s);
        exp_t e;
        int   g = 0;
        while (busy && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if (busy) begin
            tests++; fails++;
            $display("FAIL issue_timeout: busy still 1 after %0d cycles", g);
        end
        bcd = b; sinal = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = model(b, s);
        e.cyc += cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || busy) && g < 300) begin
            @(posedge clk); #1; g++;
        end
        if (q.size() != 0 || busy) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
            q.delete();
        end
    endtask

    // Monitor: compares each done pulse against the scoreboard head and
    // flags any bin/erro change that is not on a done cycle.
    logic [15:0] pb = 16'h0;
    logic        pe = 1'b0;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: bin=0x%0h erro=%0b at cycle %0d", bin, erro, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result_bin", 32'(bin), 32'(e.bin));
                check("result_erro", 32'(erro), 32'(e.erro));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (rst_n && (bin !== pb || erro !== pe)) begin
            tests++; fails++;
            $display("FAIL hold: bin/erro changed to 0x%0h/%0b without done (was 0x%0h/%0b)",
                     bin, erro, pb, pe);
        end
        pb = bin;
        pe = erro;
    end

    initial begin
        int e0;
        int bc;
        int g;
        logic [19:0] b;

        rst_n = 1'b0; start = 1'b0; sinal = 1'b0; bcd = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin", 32'(bin), 32'h0);
        check("rst_erro", 32'(erro), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 12345 positive, with busy-length measurement
        issue(20'h12345, 1'b0);
        bc = 0; g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            if (busy) bc++;
            g++;
        end
        check("busy_cycles", 32'(bc), 32'd19);
        drain();

        // Directed patterns and range boundaries
        issue(20'h00042, 1'b1);
        issue(20'h00000, 1'b1);
        issue(20'h32767, 1'b0);
        issue(20'h32768, 1'b1);
        issue(20'h32768, 1'b0);
        issue(20'h99999, 1'b1);
        issue(20'h32769, 1'b1);
        issue(20'h1A000, 1'b0);
        issue(20'h00007, 1'b0);
        issue(20'h0000F, 1'b1);
        drain();

        // Start re-pulsed mid-SHIFT is ignored
        issue(20'h00100, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        bcd = 20'h00555; sinal = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // Start held through the done cycle: second run 20 cycles later
        bcd = 20'h00321; sinal = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        begin
            exp_t e;
            e = model(20'h00321, 1'b0); e.cyc += e0;      q.push_back(e);
            e = model(20'h00654, 1'b1); e.cyc += e0 + 20; q.push_back(e);
        end
        bcd = 20'h00654; sinal = 1'b1;
        g = 0;
        while (cyc < e0 + 20 && g < 100) begin
            @(posedge clk); #1; g++;
        end
        start = 1'b0;
        drain();

        // Reset mid-SHIFT: immediate clear, no done, bin stays 0
        issue(20'h00007, 1'b0);
        drain();
        issue(20'h54321, 1'b0);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(q.pop_back());
        #1;
        check("abort_bin", 32'(bin), 32'h0);
        check("abort_erro", 32'(erro), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_abort_bin", 32'(bin), 32'h0);
        check("post_abort_busy", 32'(busy), 32'h0);

        // Randomized conversions, some with an invalid digit planted
        for (int n = 0; n < 40; n++) begin
            int k;
            b = to_bcd(int'($urandom_range(0, 99999)));
            if ($urandom_range(0, 5) == 0) begin
                k = int'($urandom_range(0, 4));
                b[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            issue(b, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
